// File: rtl/elevator_motion_ctrl.sv
// Four-floor elevator motion controller.
// Latches floor calls into lamp-driving pending bits and moves the car one motor
// step per clock. Once a direction is chosen, the car keeps it while calls remain
// beyond the car, then it reverses. The door opens for a fixed number of cycles at
// each served floor. Every output is registered.
module elevator_motion_ctrl #(
  parameter int unsigned STEPS_PER_FLOOR = 8,  // 2..255
  parameter int unsigned DOOR_CYCLES     = 16  // 1..255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [1:0] direction,
  output logic [1:0] cur_floor,
  output logic       door_open,
  output logic [3:0] pending,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_UP,
    S_DOWN,
    S_DOOR
  } state_t;

  localparam logic [1:0] DIR_UP    = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_STOP  = 2'b11;
  localparam logic [7:0] STEP_LAST = 8'(STEPS_PER_FLOOR - 1);
  localparam logic [7:0] DOOR_LAST = 8'(DOOR_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] step_cnt_q;
  logic [7:0] door_cnt_q;
  logic       last_up_q;
  logic [1:0] cur_floor_q, floor_d;
  logic [3:0] pending_q, pending_d;
  logic [1:0] direction_q;
  logic       door_open_q;
  logic       busy_q;
  logic       arrive;
  logic       call_fwd;
  logic       call_back;

  // Any latched call on a floor strictly above f.
  function automatic logic calls_above(input logic [1:0] f, input logic [3:0] p);
    return |(p & (4'b1110 << f));
  endfunction

  // Any latched call on a floor strictly below f.
  function automatic logic calls_below(input logic [1:0] f, input logic [3:0] p);
    return |(p & ~(4'b1111 << f));
  endfunction

  // Next-state, arrival floor and next pending-call decode.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    state_d   = state_q;
    floor_d   = cur_floor_q;
    arrive    = 1'b0;
    call_fwd  = 1'b0;
    call_back = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // A call at the current floor wins over any motion.
        if (pending_q[cur_floor_q]) begin
          state_d = S_DOOR;
        end else if (last_up_q && calls_above(cur_floor_q, pending_q)) begin
          state_d = S_UP;
        end else if (calls_below(cur_floor_q, pending_q)) begin
          state_d = S_DOWN;
        end else if (calls_above(cur_floor_q, pending_q)) begin
          state_d = S_UP;
        end
      end
      S_UP, S_DOWN: begin
        if (step_cnt_q == STEP_LAST) begin
          arrive    = 1'b1;
          floor_d   = (state_q == S_UP) ? cur_floor_q + 2'd1 : cur_floor_q - 2'd1;
          call_fwd  = (state_q == S_UP) ? calls_above(floor_d, pending_q)
                                        : calls_below(floor_d, pending_q);
          call_back = (state_q == S_UP) ? calls_below(floor_d, pending_q)
                                        : calls_above(floor_d, pending_q);
          if (pending_q[floor_d]) begin
            state_d = S_DOOR;
          end else if (call_fwd) begin
            state_d = state_q;
          end else if (call_back) begin
            state_d = (state_q == S_UP) ? S_DOWN : S_UP;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DOOR: begin
        if (door_cnt_q == DOOR_LAST) state_d = S_IDLE;
      end
    endcase

    // Calls accumulate, but the floor the door is open at can never latch. The
    // edge that opens the door and the edge that closes it also drop that floor.
    pending_d = pending_q | req;
    if (state_q == S_DOOR || state_d == S_DOOR) pending_d[floor_d] = 1'b0;
  end

  // Controller state, counters and registered outputs; synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value, independent of statement order.
    if (rst) begin
      state_q     <= S_IDLE;
      step_cnt_q  <= '0;
      door_cnt_q  <= '0;
      last_up_q   <= 1'b1;
      cur_floor_q <= '0;
      pending_q   <= '0;
      direction_q <= DIR_STOP;
      door_open_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_floor_q <= floor_d;
      pending_q   <= pending_d;
      step_cnt_q  <= ((state_q == S_UP || state_q == S_DOWN) && !arrive) ?
                     step_cnt_q + 8'd1 : 8'd0;
      door_cnt_q  <= (state_q == S_DOOR && state_d == S_DOOR) ?
                     door_cnt_q + 8'd1 : 8'd0;
      if (state_d == S_UP)   last_up_q <= 1'b1;
      if (state_d == S_DOWN) last_up_q <= 1'b0;
      unique case (state_d)
        S_UP:    direction_q <= DIR_UP;
        S_DOWN:  direction_q <= DIR_DOWN;
        default: direction_q <= DIR_STOP;
      endcase
      door_open_q <= (state_d == S_DOOR);
      busy_q      <= (state_d != S_IDLE);
    end
  end

  assign direction = direction_q;
  assign cur_floor = cur_floor_q;
  assign door_open = door_open_q;
  assign pending   = pending_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_elevator_motion_ctrl.sv
// Self-checking bench for elevator_motion_ctrl (4 steps per floor, 3 door cycles).
// Each scenario pushes the expected sequence of visible car changes
// (direction, floor, door) into a scoreboard queue. A negedge monitor pops one
// entry each time the DUT outputs change. Timing-critical points are also
// checked inline.
module tb_elevator_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0;
  logic [1:0] direction;
  logic [1:0] cur_floor;
  logic       door_open;
  logic [3:0] pending;
  logic       busy;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [1:0] dir;
    logic [1:0] floor;
    logic       door;
  } ev_t;

  ev_t  sb[$];
  ev_t  prev_snap;
  logic mon_en = 1'b0;

  elevator_motion_ctrl #(
    .STEPS_PER_FLOOR(4),
    .DOOR_CYCLES    (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .direction(direction),
    .cur_floor(cur_floor),
    .door_open(door_open),
    .pending  (pending),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Scoreboard consumer: every change of the visible car state pops one entry.
  always @(negedge clk) begin : sb_mon
    ev_t snap;
    ev_t exp_ev;
    if (mon_en) begin
      snap = {direction, cur_floor, door_open};
      if (snap !== prev_snap) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got dir=%b floor=%0d door=%b, expected no further change",
                   snap.dir, snap.floor, snap.door);
        end else begin
          exp_ev = sb.pop_front();
          if (snap !== exp_ev) begin
            errors++;
            $display("FAIL sb_event: got dir=%b floor=%0d door=%b, expected dir=%b floor=%0d door=%b",
                     snap.dir, snap.floor, snap.door, exp_ev.dir, exp_ev.floor, exp_ev.door);
          end
        end
        prev_snap = snap;
      end
    end
  end

  task automatic push_ev(input logic [1:0] d, input logic [1:0] f, input logic o);
    sb.push_back(ev_t'({d, f, o}));
  endtask

  task automatic start_mon();
    prev_snap = {direction, cur_floor, door_open};
    mon_en    = 1'b1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 4'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Bounded wait for an idle car with nothing pending.
  task automatic wait_idle(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (!busy && !door_open && pending == 4'b0) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 4'b1111;
    repeat (2) @(negedge clk);
    checks++; if (direction !== 2'b11) begin errors++; $display("FAIL reset_dir: got %b expected 11", direction); end
    checks++; if (cur_floor !== 2'd0) begin errors++; $display("FAIL reset_floor: got %0d expected 0", cur_floor); end
    checks++; if (door_open !== 1'b0) begin errors++; $display("FAIL reset_door: got %b expected 0", door_open); end
    checks++; if (pending !== 4'b0) begin errors++; $display("FAIL reset_pending: got %b expected 0000", pending); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0;
    req = 4'b0;
  endtask

  task automatic test_single_call();
    logic [1:0] exp_floor;
    apply_reset();
    start_mon();
    push_ev(2'b01, 2'd0, 1'b0);
    push_ev(2'b01, 2'd1, 1'b0);
    push_ev(2'b11, 2'd2, 1'b1);
    push_ev(2'b11, 2'd2, 1'b0);
    req = 4'b0100;
    @(negedge clk);
    req = 4'b0;
    checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL single_latch: got %b expected 0100", pending); end
    checks++; if (direction !== 2'b11) begin errors++; $display("FAIL single_latency: got %b expected 11", direction); end
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      exp_floor = (k < 4) ? 2'd0 : 2'd1;
      checks++;
      if (direction !== 2'b01 || cur_floor !== exp_floor) begin
        errors++;
        $display("FAIL single_travel[%0d]: got dir=%b floor=%0d expected dir=01 floor=%0d",
                 k, direction, cur_floor, exp_floor);
      end
      @(negedge clk);
    end
    checks++;
    if (door_open !== 1'b1 || direction !== 2'b11 || cur_floor !== 2'd2 || pending !== 4'b0) begin
      errors++;
      $display("FAIL single_arrive: got door=%b dir=%b floor=%0d pending=%b expected 1 11 2 0000",
               door_open, direction, cur_floor, pending);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (door_open !== 1'b1) begin errors++; $display("FAIL single_door_hold[%0d]: got %b expected 1", i, door_open); end
    end
    @(negedge clk);
    checks++;
    if (door_open !== 1'b0 || busy !== 1'b0 || direction !== 2'b11) begin
      errors++;
      $display("FAIL single_idle: got door=%b busy=%b dir=%b expected 0 0 11", door_open, busy, direction);
    end
    @(negedge clk);
    mon_en = 1'b0;
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL single_sb_left: got %0d events left expected 0", sb.size()); end
    sb.delete();
  endtask

  task automatic test_door_here();
    int  door_cycles;
    bit  moved;
    apply_reset();
    start_mon();
    push_ev(2'b11, 2'd0, 1'b1);
    push_ev(2'b11, 2'd0, 1'b0);
    door_cycles = 0;
    moved       = 1'b0;
    req = 4'b0001;
    @(negedge clk);
    req = 4'b0;
    checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL here_latch: got %b expected 0001", pending); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (direction == 2'b01 || direction == 2'b10) moved = 1'b1;
      if (door_open) door_cycles++;
      if (i == 0) begin
        checks++;
        if (door_open !== 1'b1 || pending !== 4'b0) begin
          errors++;
          $display("FAIL here_entry: got door=%b pending=%b expected 1 0000", door_open, pending);
        end
      end
      if (i == 1) req = 4'b0001;
      if (i == 2) req = 4'b0;
    end
    checks++; if (moved !== 1'b0) begin errors++; $display("FAIL here_moved: got %b expected 0", moved); end
    checks++; if (door_cycles != 3) begin errors++; $display("FAIL here_door_len: got %0d expected 3", door_cycles); end
    checks++; if (pending !== 4'b0) begin errors++; $display("FAIL here_relatch: got %b expected 0000", pending); end
    @(negedge clk);
    mon_en = 1'b0;
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL here_sb_left: got %0d events left expected 0", sb.size()); end
    sb.delete();
  endtask

  task automatic test_intermediate_stop();
    bit ok;
    apply_reset();
    start_mon();
    push_ev(2'b01, 2'd0, 1'b0);
    push_ev(2'b11, 2'd1, 1'b1);
    push_ev(2'b11, 2'd1, 1'b0);
    push_ev(2'b01, 2'd1, 1'b0);
    push_ev(2'b01, 2'd2, 1'b0);
    push_ev(2'b11, 2'd3, 1'b1);
    push_ev(2'b11, 2'd3, 1'b0);
    req = 4'b1000;
    @(negedge clk);
    req = 4'b0;
    repeat (2) @(negedge clk);
    req = 4'b0010;
    @(negedge clk);
    req = 4'b0;
    wait_idle(60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_timeout: got no idle expected idle within 60 cycles"); end
    checks++; if (cur_floor !== 2'd3) begin errors++; $display("FAIL mid_final_floor: got %0d expected 3", cur_floor); end
    mon_en = 1'b0;
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL mid_sb_left: got %0d events left expected 0", sb.size()); end
    sb.delete();
  endtask

  task automatic test_late_call();
    bit ok;
    apply_reset();
    start_mon();
    push_ev(2'b01, 2'd0, 1'b0);
    push_ev(2'b01, 2'd1, 1'b0);
    push_ev(2'b01, 2'd2, 1'b0);
    push_ev(2'b11, 2'd3, 1'b1);
    push_ev(2'b11, 2'd3, 1'b0);
    push_ev(2'b10, 2'd3, 1'b0);
    push_ev(2'b10, 2'd2, 1'b0);
    push_ev(2'b11, 2'd1, 1'b1);
    push_ev(2'b11, 2'd1, 1'b0);
    req = 4'b1000;
    @(negedge clk);
    req = 4'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (cur_floor !== 2'd1 || direction !== 2'b01) begin
      errors++;
      $display("FAIL late_pass_floor1: got floor=%0d dir=%b expected 1 01", cur_floor, direction);
    end
    req = 4'b0010;
    @(negedge clk);
    req = 4'b0;
    wait_idle(80, ok);
    checks++; if (!ok) begin errors++; $display("FAIL late_timeout: got no idle expected idle within 80 cycles"); end
    checks++; if (cur_floor !== 2'd1) begin errors++; $display("FAIL late_final_floor: got %0d expected 1", cur_floor); end
    mon_en = 1'b0;
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL late_sb_left: got %0d events left expected 0", sb.size()); end
    sb.delete();
  endtask

  task automatic test_back_to_back();
    bit ok;
    apply_reset();
    req = 4'b1000;
    @(negedge clk);
    req = 4'b0;
    wait_idle(60, ok);
    checks++;
    if (!ok || cur_floor !== 2'd3) begin
      errors++;
      $display("FAIL b2b_setup: got ok=%b floor=%0d expected 1 3", ok, cur_floor);
    end
    start_mon();
    push_ev(2'b10, 2'd3, 1'b0);
    push_ev(2'b11, 2'd2, 1'b1);
    push_ev(2'b11, 2'd2, 1'b0);
    push_ev(2'b10, 2'd2, 1'b0);
    push_ev(2'b10, 2'd1, 1'b0);
    push_ev(2'b11, 2'd0, 1'b1);
    push_ev(2'b11, 2'd0, 1'b0);
    req = 4'b0101;
    @(negedge clk);
    req = 4'b0;
    checks++; if (pending !== 4'b0101) begin errors++; $display("FAIL b2b_latch: got %b expected 0101", pending); end
    wait_idle(80, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: got no idle expected idle within 80 cycles"); end
    checks++; if (cur_floor !== 2'd0) begin errors++; $display("FAIL b2b_final_floor: got %0d expected 0", cur_floor); end
    mon_en = 1'b0;
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b_sb_left: got %0d events left expected 0", sb.size()); end
    sb.delete();
  endtask

  task automatic test_reset_mid_motion();
    apply_reset();
    req = 4'b1000;
    @(negedge clk);
    req = 4'b0;
    repeat (7) @(negedge clk);
    checks++;
    if (cur_floor !== 2'd1 || direction !== 2'b01 || pending !== 4'b1000) begin
      errors++;
      $display("FAIL rstmove_pre: got floor=%0d dir=%b pending=%b expected 1 01 1000",
               cur_floor, direction, pending);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (direction !== 2'b11 || cur_floor !== 2'd0 || door_open !== 1'b0 || pending !== 4'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmove_post: got dir=%b floor=%0d door=%b pending=%b busy=%b expected 11 0 0 0000 0",
               direction, cur_floor, door_open, pending, busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_door();
    bit found;
    apply_reset();
    req   = 4'b1000;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (door_open) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found || cur_floor !== 2'd3) begin
      errors++;
      $display("FAIL rstdoor_reach: got found=%b floor=%0d expected 1 3", found, cur_floor);
    end
    @(negedge clk);
    checks++;
    if (pending !== 4'b0 || door_open !== 1'b1) begin
      errors++;
      $display("FAIL rstdoor_held_req: got pending=%b door=%b expected 0000 1", pending, door_open);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (direction !== 2'b11 || cur_floor !== 2'd0 || door_open !== 1'b0 || pending !== 4'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstdoor_post: got dir=%b floor=%0d door=%b pending=%b busy=%b expected 11 0 0 0000 0",
               direction, cur_floor, door_open, pending, busy);
    end
    rst = 1'b0;
    req = 4'b0;
  endtask

  initial begin
    test_reset();
    test_single_call();
    test_door_here();
    test_intermediate_stop();
    test_late_call();
    test_back_to_back();
    test_reset_mid_motion();
    test_reset_mid_door();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish before 100000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/elevator_motion_ctrl.md
ELEVATOR_MOTION_CTRL -- requirements
Module: elevator_motion_ctrl

Interface
REQ-001 Parameter STEPS_PER_FLOOR, default 8: motor steps between adjacent floors, legal range 2..255.
REQ-002 Parameter DOOR_CYCLES, default 16: cycles the door stays open, legal range 1..255.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  rising-edge system clock, one motor step per clk while moving.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req  input  4  floor call buttons, bit i = floor i, sampled every clk, may be pulsed or held.
REQ-007 direction  output  2  motor command: 2'b01 up, 2'b10 down, 2'b11 stop; 2'b00 is never driven.
REQ-008 cur_floor  output  2  current floor, 0..3.
REQ-009 door_open  output  1  high while the door is open.
REQ-010 pending  output  4  latched outstanding calls, drives the button lamps.
REQ-011 busy  output  1  high when the state is not IDLE.

Function
REQ-012 All outputs SHALL be registered.
REQ-013 Every clk, pending SHALL be set to pending | req, except the cur_floor bit while in DOOR, which SHALL be held at 0.
REQ-014 States are IDLE, UP, DOWN and DOOR; direction SHALL be 01 in UP, 10 in DOWN, and 11 in IDLE and DOOR.
REQ-015 IDLE, pending[cur_floor]=1: next state SHALL be DOOR; this check has priority over motion.
REQ-016 IDLE, no call at cur_floor: if last_dir=up and a call exists above, next state SHALL be UP; else if a call exists below, DOWN; else if a call exists above, UP; else stay in IDLE.
REQ-017 last_dir SHALL record the direction of the most recent UP/DOWN state; its reset value is up.
REQ-018 UP/DOWN: a 8-bit step_cnt SHALL increment every cycle in the state.
REQ-019 On the cycle step_cnt = STEPS_PER_FLOOR-1: step_cnt SHALL clear to 0 and cur_floor SHALL change by +1 (UP) or -1 (DOWN).
REQ-020 On that arrival edge, next state SHALL be: DOOR if pending[new floor]=1; else the same direction if a call exists beyond the new floor; else the opposite direction if a call exists behind it; else IDLE.
REQ-021 Floors SHALL be passed only at arrival edges; a call for a floor already left is served after reversal.
REQ-022 cur_floor SHALL never exceed 3 or go below 0; UP SHALL never be entered at floor 3, nor DOWN at floor 0.
REQ-023 On DOOR entry: door_open SHALL go high, door_cnt SHALL load 0 and pending[cur_floor] SHALL clear on the same edge.
REQ-024 DOOR SHALL last exactly DOOR_CYCLES cycles, then go to IDLE with door_open low; a new call at cur_floor during DOOR is discarded and does not extend the door time.
REQ-025 Latency: a req sampled at edge n in IDLE SHALL show in pending after edge n; direction or door_open SHALL change after edge n+1.
REQ-026 Simultaneous calls SHALL all latch; service order is decided only by REQ-016 and REQ-020.

Reset
REQ-027 While rst=1 at a clk edge: state=IDLE, direction=2'b11, cur_floor=0, door_open=0, pending=0, busy=0, step_cnt=0, door_cnt=0, last_dir=up.
REQ-028 Reset SHALL override all activity, including mid-step and mid-door.
REQ-029 Motor position is not tracked across reset; the car is taken to be at floor 0.

Verification (STEPS_PER_FLOOR=4, DOOR_CYCLES=3)
REQ-030 Reset, one-cycle pulse req=4'b0100 -> the bench SHALL check: pending=0100; direction=01 for 8 cycles; cur_floor 1 after 4 cycles and 2 after 8; then door_open=1 and direction=11 for 3 cycles; pending=0; IDLE with busy=0.
REQ-031 IDLE at floor 0, req=4'b0001 -> the bench SHALL check: no 01/10 command is ever issued; door_open=1 for 3 cycles; pending[0] clears on DOOR entry.
REQ-032 Moving up from 0 toward 3, req[1] pulsed at step 1 -> the bench SHALL check: the car stops at floor 1 (DOOR), then resumes UP to 3.
REQ-033 Same run, req[1] pulsed after floor 1 is reached -> the bench SHALL check: the car serves floor 3, then runs DOWN to floor 1.
REQ-034 At floor 3, req=4'b0101 in one cycle -> the bench SHALL check: DOWN, DOOR at floor 2, DOWN, DOOR at floor 0, IDLE.
REQ-035 rst asserted during UP step 2, and separately during DOOR -> the bench SHALL check: on the next edge direction=11, cur_floor=0, door_open=0, pending=0; a req held at 4'b1000 during DOOR at floor 3 is not re-latched.
